video_timing_gen: RTL

- Parametrised raster timing generator for the pixel-clock domain. It generalises the fixed 640x480 VGA generator.
- Provides configurable active, porch and sync geometry, configurable sync polarity, and an active-pixel coordinate bus.
- Provides frame and line start strobes, plus a look-ahead pixel-request port so a frame buffer or thermal-image upscaler can fetch pixels early.
- Includes built-in selectable test patterns. Sits between the framebuffer reader and the TMDS/VGA output encoder.

---
 rtl/video_timing_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, a look-ahead pixel request
// port, and a delayed video/sync path carrying built-in test patterns.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LOOKAHEAD = 2,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic            i_clk_pixel,
  input  logic            i_rst,
  input  logic [1:0]      i_pattern_sel,
  input  logic [2:0][7:0] i_ext_data,
  output logic            o_req_valid,
  output logic [XW-1:0]   o_req_x,
  output logic [YW-1:0]   o_req_y,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_blank,
  output logic            o_de,
  output logic [XW-1:0]   o_x,
  output logic [YW-1:0]   o_y,
  output logic            o_frame_start,
  output logic            o_line_start,
  output logic [2:0][7:0] o_data
);

  if (LOOKAHEAD < 0 || LOOKAHEAD > 8 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("video_timing_gen: LOOKAHEAD must be 0..8 and all geometry parameters non-zero");
  end

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);
  localparam logic [XW+2:0] H_ACT_W = (XW+3)'(H_ACTIVE);

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
    logic          ls;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } vid_t;

  logic [XW-1:0] h;
  logic [YW-1:0] v;

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      h <= '0;
      v <= '0;
    end else if (int'(h) == H_TOTAL - 1) begin
      h <= '0;
      v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  logic active;
  vid_t s0;

  assign active = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);

  always_comb begin
    s0    = '0;
    s0.act = active;
    s0.hs  = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
    s0.vs  = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
    s0.fs  = active && (h == '0) && (v == '0);
    s0.ls  = active && (h == '0);
    s0.x   = active ? h : '0;
    s0.y   = active ? v : '0;
  end

  logic          req_valid_q;
  logic [XW-1:0] req_x_q;
  logic [YW-1:0] req_y_q;

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      req_valid_q <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
    end else begin
      req_valid_q <= s0.act;
      req_x_q     <= s0.x;
      req_y_q     <= s0.y;
    end
  end

  // pipe[LOOKAHEAD] is the output stage; a flushed stage reads as blank, sync idle
  vid_t pipe [0:LOOKAHEAD];

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      for (int i = 0; i <= LOOKAHEAD; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i <= LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Pattern pixel is built from whatever enters the output stage this cycle
  logic          pre_act;
  logic [XW-1:0] pre_x;
  logic [YW-1:0] pre_y;

  if (LOOKAHEAD == 0) begin : g_pre_s0
    assign pre_act = s0.act;
    assign pre_x   = s0.x;
    assign pre_y   = s0.y;
  end else begin : g_pre_pipe
    assign pre_act = pipe[LOOKAHEAD-1].act;
    assign pre_x   = pipe[LOOKAHEAD-1].x;
    assign pre_y   = pipe[LOOKAHEAD-1].y;
  end

  logic [XW+2:0]   bar_prod;
  logic [2:0]      bar;
  logic [7:0]      x8;
  logic [7:0]      y8;
  logic [2:0][7:0] pat;

  always_comb begin
    bar_prod = {pre_x, 3'b000};
    bar      = 3'(bar_prod / H_ACT_W);
    x8       = 8'(pre_x);
    y8       = 8'(pre_y);
    pat      = '0;
    case (i_pattern_sel)
      2'd0:    pat = {y8, x8, 8'h00};
      2'd1:    pat = {{8{bar[0]}}, {8{bar[1]}}, {8{bar[2]}}};
      2'd2:    pat = {3{{8{x8[5] ^ y8[5]}}}};
      default: pat = i_ext_data;
    endcase
    if (!pre_act) pat = '0;
  end

  logic [2:0][7:0] data_q;

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) data_q <= '0;
    else       data_q <= pat;
  end

  assign o_req_valid   = req_valid_q;
  assign o_req_x       = req_x_q;
  assign o_req_y       = req_y_q;
  assign o_hsync       = pipe[LOOKAHEAD].hs ? HS_ON : ~HS_ON;
  assign o_vsync       = pipe[LOOKAHEAD].vs ? VS_ON : ~VS_ON;
  assign o_blank       = ~pipe[LOOKAHEAD].act;
  assign o_de          = pipe[LOOKAHEAD].act;
  assign o_x           = pipe[LOOKAHEAD].x;
  assign o_y           = pipe[LOOKAHEAD].y;
  assign o_frame_start = pipe[LOOKAHEAD].fs;
  assign o_line_start  = pipe[LOOKAHEAD].ls;
  assign o_data        = data_q;

endmodule
